// File: rtl/aes_inv_shift_rows_serial.sv
// Byte-serial AES (Inv)ShiftRows stage: a two-bank ping-pong store written in arrival
// order and read back in permuted order, one byte per cycle on each side.
module aes_inv_shift_rows_serial #(
  parameter int unsigned INVERSE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_err
);

  // Output position -> stored byte index. Byte k is row k%4, column k/4.
  function automatic logic [3:0] perm(input logic [3:0] idx);
    logic [3:0] p;
    p = 4'd0;
    if (INVERSE != 0) begin
      case (idx)
        4'd0:  p = 4'd0;   4'd1:  p = 4'd13;  4'd2:  p = 4'd10;  4'd3:  p = 4'd7;
        4'd4:  p = 4'd4;   4'd5:  p = 4'd1;   4'd6:  p = 4'd14;  4'd7:  p = 4'd11;
        4'd8:  p = 4'd8;   4'd9:  p = 4'd5;   4'd10: p = 4'd2;   4'd11: p = 4'd15;
        4'd12: p = 4'd12;  4'd13: p = 4'd9;   4'd14: p = 4'd6;   default: p = 4'd3;
      endcase
    end else begin
      case (idx)
        4'd0:  p = 4'd0;   4'd1:  p = 4'd5;   4'd2:  p = 4'd10;  4'd3:  p = 4'd15;
        4'd4:  p = 4'd4;   4'd5:  p = 4'd9;   4'd6:  p = 4'd14;  4'd7:  p = 4'd3;
        4'd8:  p = 4'd8;   4'd9:  p = 4'd13;  4'd10: p = 4'd2;   4'd11: p = 4'd7;
        4'd12: p = 4'd12;  4'd13: p = 4'd1;   4'd14: p = 4'd6;   default: p = 4'd11;
      endcase
    end
    return p;
  endfunction

  // Bank b occupies entries 16*b .. 16*b+15.
  logic [7:0] mem_q [32];

  logic [1:0] full_q, full_d;
  logic       wr_sel_q, wr_sel_d;
  logic [3:0] wr_cnt_q, wr_cnt_d;
  logic       rd_sel_q, rd_sel_d;
  logic [3:0] rd_cnt_q, rd_cnt_d;
  logic       frame_err_q, frame_err_d;

  logic       wr_fire;
  logic       rd_fire;
  logic [3:0] rd_idx;

  always_comb begin
    in_ready  = rst_n && !full_q[wr_sel_q];
    out_valid = full_q[rd_sel_q];
    wr_fire   = in_valid && in_ready;
    rd_fire   = out_valid && out_ready;
    rd_idx    = perm(rd_cnt_q);
    out_data  = out_valid ? mem_q[{rd_sel_q, rd_idx}] : 8'h00;
    out_last  = out_valid && (rd_cnt_q == 4'd15);
    frame_err = frame_err_q;
  end

  // A bank fills while wr_sel points at it, drains while rd_sel points at it; the two
  // flag updates below never target the same bank in one cycle.
  always_comb begin
    full_d      = full_q;
    wr_sel_d    = wr_sel_q;
    wr_cnt_d    = wr_cnt_q;
    rd_sel_d    = rd_sel_q;
    rd_cnt_d    = rd_cnt_q;
    frame_err_d = 1'b0;
    if (wr_fire) begin
      wr_cnt_d    = wr_cnt_q + 4'd1;
      frame_err_d = (in_last != (wr_cnt_q == 4'd15));
      if (wr_cnt_q == 4'd15) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = !wr_sel_q;
      end
    end
    if (rd_fire) begin
      rd_cnt_d = rd_cnt_q + 4'd1;
      if (rd_cnt_q == 4'd15) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = !rd_sel_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q      <= 2'b00;
      wr_sel_q    <= 1'b0;
      wr_cnt_q    <= 4'd0;
      rd_sel_q    <= 1'b0;
      rd_cnt_q    <= 4'd0;
      frame_err_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      wr_sel_q    <= wr_sel_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_sel_q    <= rd_sel_d;
      rd_cnt_q    <= rd_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Contents need no reset: the full flags alone decide what is ever read out.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[{wr_sel_q, wr_cnt_q}] <= in_data;
    end
  end

endmodule
